// File: rtl/mul_entry_ctrl.sv
// mul_entry_ctrl: collects two hex operands from keypad events, launches the
// sequential multiplier with a start/done handshake guarded by a timeout, and
// presents operands or product on the 16-bit seven-segment display bus.
module mul_entry_ctrl #(
   parameter int W       = 8,   // operand width, multiple of 4, 4..8
   parameter int TIMEOUT = 64   // max cycles spent waiting for mul_done
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           key_valid,
   input  logic [3:0]     key_code,
   input  logic           enter,
   input  logic           mul_done,
   input  logic [2*W-1:0] mul_product,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   output logic           mul_start,
   output logic [15:0]    disp,
   output logic [2:0]     state_out,
   output logic           err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_A     = 3'd0,
      S_B     = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_SHOW  = 3'd4
   } state_t;

   state_t          state_r, state_s;
   logic [W-1:0]    a_buf_r, a_buf_s;
   logic [W-1:0]    b_buf_r, b_buf_s;
   logic [W-1:0]    mul_a_s, mul_b_s;
   logic            mul_start_s;
   logic [15:0]     disp_s;
   logic            err_s;
   logic [CW-1:0]   cnt_r, cnt_s;

   // state_out is the state register itself, so it is registered by construction
   assign state_out = state_r;

   // Next-state and next-value logic; the start pulse and the operand latch are
   // issued on the transition into S_START so they coincide with that state.
   always_comb begin
      state_s     = state_r;
      a_buf_s     = a_buf_r;
      b_buf_s     = b_buf_r;
      mul_a_s     = mul_a;
      mul_b_s     = mul_b;
      mul_start_s = 1'b0;
      disp_s      = disp;
      err_s       = err;
      cnt_s       = cnt_r;
      case (state_r)
         S_A: begin
            if (enter) begin
               state_s = S_B;
               b_buf_s = {W{1'b0}};
               disp_s  = 16'h0000;
            end else if (key_valid) begin
               // shift in the new digit; the oldest digit falls off the top
               a_buf_s = (a_buf_r << 4) | W'(key_code);
               disp_s  = 16'(a_buf_s);
            end else begin
               state_s = S_A;
            end
         end
         S_B: begin
            if (enter) begin
               state_s     = S_START;
               mul_a_s     = a_buf_r;
               mul_b_s     = b_buf_r;
               mul_start_s = 1'b1;
               cnt_s       = {CW{1'b0}};
            end else if (key_valid) begin
               b_buf_s = (b_buf_r << 4) | W'(key_code);
               disp_s  = 16'({a_buf_r, b_buf_s});
            end else begin
               state_s = S_B;
            end
         end
         S_START: begin
            cnt_s   = {CW{1'b0}};
            state_s = S_WAIT;
         end
         S_WAIT: begin
            // a result arriving on the final allowed cycle still counts
            if (mul_done) begin
               disp_s  = 16'(mul_product);
               state_s = S_SHOW;
            end else if (cnt_r == CW'(TIMEOUT - 1)) begin
               err_s   = 1'b1;
               disp_s  = 16'hEEEE;
               state_s = S_SHOW;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         S_SHOW: begin
            if (enter) begin
               err_s       = 1'b0;
               state_s     = S_START;
               mul_a_s     = a_buf_r;
               mul_b_s     = b_buf_r;
               mul_start_s = 1'b1;
               cnt_s       = {CW{1'b0}};
            end else if (key_valid) begin
               a_buf_s = W'(key_code);
               b_buf_s = {W{1'b0}};
               err_s   = 1'b0;
               disp_s  = 16'(key_code);
               state_s = S_A;
            end else begin
               state_s = S_SHOW;
            end
         end
         default: begin
            state_s = S_A;
         end
      endcase
   end

   // State and datapath registers; clr overrides every other input
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r   <= S_A;
         a_buf_r   <= {W{1'b0}};
         b_buf_r   <= {W{1'b0}};
         mul_a     <= {W{1'b0}};
         mul_b     <= {W{1'b0}};
         mul_start <= 1'b0;
         disp      <= 16'h0000;
         err       <= 1'b0;
         cnt_r     <= {CW{1'b0}};
      end else begin
         state_r   <= state_s;
         a_buf_r   <= a_buf_s;
         b_buf_r   <= b_buf_s;
         mul_a     <= mul_a_s;
         mul_b     <= mul_b_s;
         mul_start <= mul_start_s;
         disp      <= disp_s;
         err       <= err_s;
         cnt_r     <= cnt_s;
      end
   end

endmodule

// File: tb/tb_mul_entry_ctrl.sv
// tb_mul_entry_ctrl: directed scenarios followed by randomized key/enter/done
// traffic, checked every cycle against a behavioural model of the controller.
module tb_mul_entry_ctrl;

   localparam int W       = 8;
   localparam int TIMEOUT = 64;

   logic           clk = 1'b0;
   logic           clr = 1'b0;
   logic           key_valid = 1'b0;
   logic [3:0]     key_code = 4'h0;
   logic           enter = 1'b0;
   logic           mul_done = 1'b0;
   logic [2*W-1:0] mul_product = '0;
   logic [W-1:0]   mul_a, mul_b;
   logic           mul_start;
   logic [15:0]    disp;
   logic [2:0]     state_out;
   logic           err;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // behavioural model: phase numbers are the observable state_out values
   int m_phase, m_a, m_b, m_ma, m_mb, m_start, m_disp, m_err, m_waited;

   mul_entry_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
      .enter(enter), .mul_done(mul_done), .mul_product(mul_product),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .disp(disp),
      .state_out(state_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // launch the multiplier with the currently entered operands
   task automatic model_launch();
      m_ma     = m_a;
      m_mb     = m_b;
      m_start  = 1;
      m_waited = 0;
      m_phase  = 2;
   endtask

   task automatic model_update(input bit kv, input int kc, input bit en,
                               input bit md, input int prod, input bit c);
      int lim;
      lim = 1 << W;
      if (c) begin
         m_phase = 0; m_a = 0; m_b = 0; m_ma = 0; m_mb = 0;
         m_start = 0; m_disp = 0; m_err = 0; m_waited = 0;
         return;
      end
      m_start = 0;
      if (m_phase == 0) begin
         if (en) begin m_phase = 1; m_b = 0; m_disp = 0; end
         else if (kv) begin m_a = (m_a * 16 + kc) % lim; m_disp = m_a; end
      end else if (m_phase == 1) begin
         if (en) model_launch();
         else if (kv) begin m_b = (m_b * 16 + kc) % lim; m_disp = m_a * lim + m_b; end
      end else if (m_phase == 2) begin
         m_phase = 3;
      end else if (m_phase == 3) begin
         m_waited++;
         if (md) begin m_disp = prod; m_phase = 4; end
         else if (m_waited == TIMEOUT) begin m_err = 1; m_disp = 'hEEEE; m_phase = 4; end
      end else begin
         if (en) begin m_err = 0; model_launch(); end
         else if (kv) begin
            m_a = kc; m_b = 0; m_err = 0; m_disp = kc; m_phase = 0;
         end
      end
   endtask

   // one clock cycle: drive inputs, let the edge pass, advance the model
   task automatic cycle(input bit kv, input int kc, input bit en,
                        input bit md, input int prod, input bit c);
      key_valid   = kv;
      key_code    = 4'(kc);
      enter       = en;
      mul_done    = md;
      mul_product = (2*W)'(prod);
      clr         = c;
      @(posedge clk);
      model_update(kv, kc, en, md, prod, c);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   // compare every DUT output against the model on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("state_out", 32'(state_out), 32'(m_phase));
         check("mul_start", 32'(mul_start), 32'(m_start));
         check("mul_a",     32'(mul_a),     32'(m_ma));
         check("mul_b",     32'(mul_b),     32'(m_mb));
         check("disp",      32'(disp),      32'(m_disp));
         check("err",       32'(err),       32'(m_err));
      end
   end

   initial begin
      int done_mode;
      @(negedge clk);
      cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
      cmp_en = 1'b1;
      check("reset_state", 32'(state_out), 32'd0);
      check("reset_disp",  32'(disp),      32'h0);

      // operand entry and launch
      cycle(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
      check("disp_a12", 32'(disp), 32'h0012);
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      cycle(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b1, 4, 1'b0, 1'b0, 0, 1'b0);
      check("disp_1234", 32'(disp), 32'h1234);
      check("model_1234", 32'(m_disp), 32'h1234);
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      check("start_pulse", 32'(mul_start), 32'd1);
      check("mul_a_12", 32'(mul_a), 32'h12);
      check("mul_b_34", 32'(mul_b), 32'h34);
      idle(1);
      check("start_once", 32'(mul_start), 32'd0);

      // product arrives 10 cycles after the start pulse
      idle(8);
      cycle(1'b0, 0, 1'b0, 1'b1, 'h03A8, 1'b0);
      check("disp_prod", 32'(disp), 32'h03A8);
      check("state_show", 32'(state_out), 32'd4);
      check("err_ok", 32'(err), 32'd0);

      // re-run and let it time out
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      check("rerun_start", 32'(mul_start), 32'd1);
      check("rerun_a", 32'(mul_a), 32'h12);
      idle(1);
      idle(TIMEOUT - 1);
      check("err_not_early", 32'(err), 32'd0);
      idle(1);
      check("err_timeout", 32'(err), 32'd1);
      check("disp_eeee", 32'(disp), 32'hEEEE);
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      check("err_cleared", 32'(err), 32'd0);
      check("retry_start", 32'(mul_start), 32'd1);
      check("retry_b", 32'(mul_b), 32'h34);

      // keys and enter during the wait are ignored
      idle(1);
      cycle(1'b1, 9, 1'b1, 1'b0, 0, 1'b0);
      check("wait_ignore_disp", 32'(disp), 32'hEEEE);
      check("wait_ignore_a", 32'(mul_a), 32'h12);
      cycle(1'b0, 0, 1'b0, 1'b1, 'h0123, 1'b0);

      // new entry from the result screen
      cycle(1'b1, 7, 1'b0, 1'b0, 0, 1'b0);
      check("show_key_state", 32'(state_out), 32'd0);
      check("show_key_disp", 32'(disp), 32'h0007);

      // digit wrap, then key together with enter
      cycle(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
      cycle(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
      check("wrap_disp", 32'(disp), 32'h0023);
      cycle(1'b1, 5, 1'b1, 1'b0, 0, 1'b0);
      check("key_enter_state", 32'(state_out), 32'd1);
      check("key_enter_disp", 32'(disp), 32'h0);
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      check("wrap_mul_a", 32'(mul_a), 32'h23);
      check("cleared_mul_b", 32'(mul_b), 32'h00);

      // reset in S_WAIT beats a simultaneous mul_done
      idle(3);
      cycle(1'b0, 0, 1'b0, 1'b1, 'hBEEF, 1'b1);
      check("clr_state", 32'(state_out), 32'd0);
      check("clr_disp", 32'(disp), 32'h0);
      check("clr_mul_a", 32'(mul_a), 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         done_mode = ((i / 300) % 3 != 0) ? 1 : 0;
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15),
               $urandom_range(0, 5) == 0,
               (done_mode == 1) && ($urandom_range(0, 11) == 0),
               $urandom_range(0, 65535), $urandom_range(0, 399) == 0);
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
